turbo_frame_ctrl: RTL

- Frame-level sequencer for the turbo encoder.
- Collects a frame of input bytes and runs two constituent convolutional encoders in lock-step: encoder 1 on natural bit order, encoder 2 on interleaved order.
- Emits one (systematic, parity1, parity2) triplet per handshake, then two trellis-termination triplets.
- Sits between the byte source and the puncturing/serializer stage.

---
 rtl/turbo_frame_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/turbo_frame_ctrl.sv
// rtl/turbo_frame_ctrl.sv - frame sequencer driving two lock-step convolutional encoders for the turbo encoder
//
// Ports:
//   clk        clock, all logic on rising edge
//   reset      synchronous, active-high
//   in_data    frame byte; bit n of byte b is info bit 8*b+n
//   in_valid   source has a byte
//   in_ready   controller accepts a byte this cycle
//   out_sys    systematic bit
//   out_par1   encoder-1 parity (natural order)
//   out_par2   encoder-2 parity (interleaved order, pi(j) = P*j mod K)
//   out_tail   current triplet is a trellis-termination triplet
//   out_last   final triplet of the frame
//   out_valid  triplet valid
//   out_ready  sink accepts the triplet
//   busy       high while encoding or terminating

module turbo_frame_ctrl #(
    parameter int NBYTES = 5,
    parameter int P      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_sys,
    output logic       out_par1,
    output logic       out_par2,
    output logic       out_tail,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int K  = 8 * NBYTES;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [KW:0]   K_EXT  = (KW + 1)'(K);
    localparam logic [KW:0]   P_EXT  = (KW + 1)'(P % K);
    localparam logic [BW-1:0] B_LAST = BW'(NBYTES - 1);

    typedef enum logic [1:0] {LOAD, ENCODE, TAIL} state_t;

    state_t state, state_next;

    logic [K-1:0]  frame_buf;
    logic [BW-1:0] byte_cnt;
    logic [KW-1:0] k;
    logic [KW-1:0] idx2;
    logic [1:0]    tail_cnt;
    logic          a1, b1, a2, b2;

    logic          accept;
    logic          step;
    logic          last_step;
    logic          u, v;
    logic [KW:0]   idx_sum;
    logic [KW-1:0] idx_next;

    // Interleaver address advances by P modulo K with a single conditional subtract.
    assign idx_sum  = {1'b0, idx2} + P_EXT;
    assign idx_next = (idx_sum >= K_EXT) ? KW'(idx_sum - K_EXT) : idx_sum[KW-1:0];

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;
        u          = 1'b0;
        v          = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = !out_valid;
                accept   = in_valid && in_ready;
                // The k=0 step overlaps acceptance of the final byte so the first
                // triplet is registered on that same edge. pi(0)=0, so both encoders
                // take info bit 0, which lives in byte 0.
                if (accept && byte_cnt == B_LAST) begin
                    step       = 1'b1;
                    u          = (byte_cnt == '0) ? in_data[0] : frame_buf[0];
                    v          = u;
                    state_next = (K_LAST == '0) ? TAIL : ENCODE;
                end
            end
            ENCODE: begin
                busy = 1'b1;
                step = !out_valid || out_ready;
                u    = frame_buf[k];
                v    = frame_buf[idx2];
                if (step && k == K_LAST) begin
                    state_next = TAIL;
                end
            end
            TAIL: begin
                busy = 1'b1;
                if (tail_cnt != 2'd2) begin
                    step      = !out_valid || out_ready;
                    last_step = (tail_cnt == 2'd1);
                end else if (out_ready) begin
                    // Final triplet is being consumed.
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Frame storage carries no reset; it is fully rewritten before every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_buf[{byte_cnt, 3'b000} +: 8] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt  <= '0;
            k         <= '0;
            idx2      <= '0;
            tail_cnt  <= '0;
            a1        <= 1'b0;
            b1        <= 1'b0;
            a2        <= 1'b0;
            b2        <= 1'b0;
            out_sys   <= 1'b0;
            out_par1  <= 1'b0;
            out_par2  <= 1'b0;
            out_tail  <= 1'b0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt <= (byte_cnt == B_LAST) ? '0 : byte_cnt + BW'(1);
            end
            if (step) begin
                out_sys   <= u;
                out_par1  <= u ^ a1 ^ b1;
                out_par2  <= v ^ a2 ^ b2;
                out_tail  <= (state == TAIL);
                out_last  <= last_step;
                out_valid <= 1'b1;
                b1        <= a1;
                a1        <= u;
                b2        <= a2;
                a2        <= v;
                if (state == TAIL) begin
                    tail_cnt <= tail_cnt + 2'd1;
                end else if (k == K_LAST) begin
                    k    <= '0;
                    idx2 <= '0;
                end else begin
                    k    <= k + KW'(1);
                    idx2 <= idx_next;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_tail  <= 1'b0;
                out_last  <= 1'b0;
                tail_cnt  <= '0;
            end
        end
    end

endmodule
